sin_phase_seq: RTL and testbench
================================

Name: sin_phase_seq

Overview:
Upstream sequencer for the `sin` evaluation unit.
- Generates a series of Q1.15 arguments from a start phase and a signed step.
- Presents each argument to `sin` one cycle before pulsing its start, then waits for done.
- Captures each result and forwards it on a valid/ready output.
- Replaces the hand-driven x/start stimulus with a repeatable hardware stage.

Parameters:
COUNT_W, 8, width of the sample-count configuration and internal remaining counter
TIMEOUT_CYC, 64, max cycles spent in WAIT before aborting with err_timeout

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
go  input  1  one-cycle request to run a sequence; sampled only in IDLE
cfg_phase0  input  16  first argument, Q1.15 signed; latched on accepted go
cfg_step  input  16  phase increment, Q1.15 signed; latched on accepted go
cfg_count  input  COUNT_W  number of samples; latched on accepted go
busy  output  1  high whenever state is not IDLE
sin_x  output  16  argument to sin unit
sin_start  output  1  one-cycle start pulse to sin unit
sin_result  input  16  result from sin unit, Q1.15
sin_done  input  1  completion pulse from sin unit
out_data  output  16  captured result
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts when out_valid and out_ready are both high
seq_done  output  1  one-cycle pulse when a sequence ends normally
err_timeout  output  1  sticky flag: sin_done not seen within TIMEOUT_CYC; cleared on next accepted go

Behaviour:
- Reset values: state=IDLE. busy, sin_start, out_valid, seq_done and err_timeout are 0. sin_x and out_data are 0x0000. Internal counters are 0.
- Reset is synchronous and overrides everything, including mid-sequence. No output handshake completes in the reset cycle.
- States and transitions:
  - IDLE: on go, latch phase=cfg_phase0, step=cfg_step, remaining=cfg_count, and clear err_timeout. If cfg_count==0, pulse seq_done next cycle and stay IDLE. Otherwise go to SETUP.
  - SETUP (1 cycle): sin_x<=phase. Go to START.
  - START (1 cycle): sin_start=1 with sin_x stable. Clear the timeout counter. Go to WAIT.
  - WAIT: on sin_done, capture out_data<=sin_result, set out_valid=1, decrement remaining, and go to PUSH.
    - Otherwise increment the timeout counter. When it reaches TIMEOUT_CYC, set err_timeout=1 and return to IDLE with no output and no seq_done.
    - If sin_done arrives in the same cycle as expiry, sin_done wins.
  - PUSH: hold out_data and out_valid stable until out_ready. On handshake, clear out_valid and advance phase<=phase+step.
    - remaining==0: pulse seq_done and go to IDLE.
    - Otherwise go to SETUP.
- sin_x holds its last value in every state except SETUP, where it updates.
- Latency: go at cycle N → sin_x valid at N+1 → sin_start at N+2 → WAIT from N+3. sin_done at cycle M → out_valid at M+1. Handshake at cycle P → next sin_x at P+1 (SETUP).
- sin_start is never asserted outside START. At most one sin operation is outstanding.
- go is ignored while busy. sin_done is ignored outside WAIT.
- Phase arithmetic is 16-bit two's complement and wraps by default, e.g. 0x7000+0x2000=0x9000.
- cfg_* changes after go have no effect on the running sequence.

Optional Feature:
SIN_SEQ_SAT_EN
- Defined: phase+step saturates to 0x7FFF on positive overflow and 0x8000 on negative overflow.
- Undefined: the phase wraps modulo 2^16.

Test Plan:
- Basic sequence. Setup: phase0=0x0000, step=0x2000, count=3; sin model returns x+1 five cycles after start; out_ready=1. Required: sin_x = 0x0000, 0x2000, 0x4000; out_data = 0x0001, 0x2001, 0x4001; seq_done pulses once in the cycle after the third handshake; busy low afterwards.
- Backpressure. Setup: as above, with out_ready=0 for 4 cycles after the first out_valid. Required: out_data holds 0x0001 with out_valid high; no sin_start until the handshake; the next sin_x appears the cycle after out_ready rises.
- Wrap. Setup: phase0=0x7000, step=0x2000, count=2. Required: second sin_x=0x9000; with SIN_SEQ_SAT_EN defined, second sin_x=0x7FFF.
- Timeout. Setup: sin model never asserts done; count=2. Required: err_timeout=1 after 64 WAIT cycles; state returns to IDLE with no out_valid and no seq_done. A following go clears err_timeout.
- Zero count and go-while-busy. Setup: count=0, then a second go issued mid-sequence. Required: for count=0, seq_done pulses one cycle later with no sin_start. The mid-sequence go has no effect.
- Reset mid-WAIT. Setup: assert rst for 1 cycle during WAIT. Required: all outputs return to reset values on the next edge. A late sin_done is ignored and no out_valid follows.

Source files
------------

// File: rtl/sin_phase_seq_if.sv
// Bundle of the sequencer's configuration, sin-unit and result-stream signals.
// master = environment side (config source, sin unit, downstream sink); slave = sequencer.
interface sin_phase_seq_if #(
  parameter int COUNT_W = 8
);
  logic               go;
  logic [15:0]        cfg_phase0;
  logic [15:0]        cfg_step;
  logic [COUNT_W-1:0] cfg_count;
  logic               busy;
  logic [15:0]        sin_x;
  logic               sin_start;
  logic [15:0]        sin_result;
  logic               sin_done;
  logic [15:0]        out_data;
  logic               out_valid;
  logic               out_ready;
  logic               seq_done;
  logic               err_timeout;

  modport master (
    output go, cfg_phase0, cfg_step, cfg_count, sin_result, sin_done, out_ready,
    input  busy, sin_x, sin_start, out_data, out_valid, seq_done, err_timeout
  );

  modport slave (
    input  go, cfg_phase0, cfg_step, cfg_count, sin_result, sin_done, out_ready,
    output busy, sin_x, sin_start, out_data, out_valid, seq_done, err_timeout
  );
endinterface

// File: rtl/sin_phase_seq.sv
// Phase-stepping sequencer that feeds the sin unit and streams its results out.
// Define SIN_SEQ_SAT_EN to saturate phase+step instead of wrapping modulo 2^16.
module sin_phase_seq #(
  parameter int COUNT_W     = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic            clk,
  input  logic            rst,
  sin_phase_seq_if.slave  bus
);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {IDLE, SETUP, START, WAIT, PUSH} state_e;

  state_e             state_q, state_d;
  logic [15:0]        phase_q, phase_d;
  logic [15:0]        step_q, step_d;
  logic [15:0]        sin_x_q, sin_x_d;
  logic [15:0]        out_data_q, out_data_d;
  logic [COUNT_W-1:0] remaining_q, remaining_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               out_valid_q, out_valid_d;
  logic               seq_done_q, seq_done_d;
  logic               err_q, err_d;
  logic [15:0]        phase_next;

  always_comb begin
    phase_next = phase_q + step_q;
`ifdef SIN_SEQ_SAT_EN
    // Overflow only when both operands share a sign and the sum flips it.
    if ((phase_q[15] == step_q[15]) && (phase_next[15] != phase_q[15]))
      phase_next = phase_q[15] ? 16'h8000 : 16'h7FFF;
`endif
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    step_d      = step_q;
    sin_x_d     = sin_x_q;
    out_data_d  = out_data_q;
    remaining_d = remaining_q;
    tmo_d       = tmo_q;
    out_valid_d = out_valid_q;
    seq_done_d  = 1'b0;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (bus.go) begin
          phase_d     = bus.cfg_phase0;
          step_d      = bus.cfg_step;
          remaining_d = bus.cfg_count;
          err_d       = 1'b0;
          if (bus.cfg_count == '0) begin
            seq_done_d = 1'b1;
          end else begin
            // sin_x is loaded on entry so it is already valid during SETUP.
            sin_x_d = bus.cfg_phase0;
            state_d = SETUP;
          end
        end
      end
      SETUP: state_d = START;
      START: begin
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.sin_done) begin
          out_data_d  = bus.sin_result;
          out_valid_d = 1'b1;
          remaining_d = remaining_q - 1'b1;
          state_d     = PUSH;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          tmo_d   = tmo_q + 1'b1;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      PUSH: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          phase_d     = phase_next;
          if (remaining_q == '0) begin
            seq_done_d = 1'b1;
            state_d    = IDLE;
          end else begin
            sin_x_d = phase_next;
            state_d = SETUP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      step_q      <= '0;
      sin_x_q     <= '0;
      out_data_q  <= '0;
      remaining_q <= '0;
      tmo_q       <= '0;
      out_valid_q <= 1'b0;
      seq_done_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      step_q      <= step_d;
      sin_x_q     <= sin_x_d;
      out_data_q  <= out_data_d;
      remaining_q <= remaining_d;
      tmo_q       <= tmo_d;
      out_valid_q <= out_valid_d;
      seq_done_q  <= seq_done_d;
      err_q       <= err_d;
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.sin_start   = (state_q == START);
  assign bus.sin_x       = sin_x_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.seq_done    = seq_done_q;
  assign bus.err_timeout = err_q;
endmodule

// File: tb/tb_sin_phase_seq.sv
// Directed bench for sin_phase_seq with a behavioural sin unit returning x+1
// five cycles after each start pulse.
module tb_sin_phase_seq;
  localparam int COUNT_W     = 8;
  localparam int TIMEOUT_CYC = 64;
`ifdef SIN_SEQ_SAT_EN
  localparam logic [15:0] EXP_WRAP = 16'h7FFF;
`else
  localparam logic [15:0] EXP_WRAP = 16'h9000;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sin_phase_seq_if #(.COUNT_W(COUNT_W)) bus ();

  sin_phase_seq #(.COUNT_W(COUNT_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [15:0] start_xs[$];
  logic [15:0] outs[$];
  int          start_cnt = 0;
  int          done_cnt  = 0;
  int          hs_cyc    = 0;
  int          sd_cyc    = 0;
  int          start_cyc = 0;
  bit          ov_seen   = 1'b0;
  bit          model_en  = 1'b1;
  int          mcnt      = 0;
  logic [15:0] mx        = 16'h0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor and sin model, both evaluated mid-cycle.
  always @(negedge clk) begin
    if (bus.sin_start) begin
      start_xs.push_back(bus.sin_x);
      start_cnt++;
      start_cyc = cyc;
    end
    if (bus.out_valid) ov_seen = 1'b1;
    if (bus.out_valid && bus.out_ready && !rst) begin
      outs.push_back(bus.out_data);
      hs_cyc = cyc;
      $display("out handshake cyc=%0d data=%h", cyc, bus.out_data);
    end
    if (bus.seq_done) begin
      done_cnt++;
      sd_cyc = cyc;
    end
    bus.sin_done = 1'b0;
    if (bus.sin_start) begin
      mcnt = 5;
      mx   = bus.sin_x;
    end else if (mcnt > 0) begin
      mcnt--;
      if (mcnt == 0 && model_en) begin
        bus.sin_done   = 1'b1;
        bus.sin_result = mx + 16'd1;
      end
    end
  end

  task automatic clear_logs();
    start_xs.delete();
    outs.delete();
    done_cnt = 0;
    ov_seen  = 1'b0;
  endtask

  task automatic issue_go(input logic [15:0] p0, input logic [15:0] st, input logic [COUNT_W-1:0] cnt);
    bus.cfg_phase0 = p0;
    bus.cfg_step   = st;
    bus.cfg_count  = cnt;
    bus.go         = 1'b1;
    @(negedge clk);
    bus.go         = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    int n = 0;
    while (bus.busy && n < 600) begin
      @(negedge clk);
      n++;
    end
    ok = !bus.busy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.busy, bus.sin_start, bus.out_valid, bus.seq_done, bus.err_timeout} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=00000",
               {bus.busy, bus.sin_start, bus.out_valid, bus.seq_done, bus.err_timeout});
    end
    total++;
    if ({bus.sin_x, bus.out_data} !== 32'h0) begin
      bad++;
      $display("FAIL reset_data got sin_x=%h out_data=%h exp=0000/0000", bus.sin_x, bus.out_data);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit ok;
    logic [15:0] ex[3] = '{16'h0000, 16'h2000, 16'h4000};
    logic [15:0] eo[3] = '{16'h0001, 16'h2001, 16'h4001};
    logic [15:0] got;
    clear_logs();
    bus.out_ready = 1'b1;
    issue_go(16'h0000, 16'h2000, 8'd3);
    wait_idle(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL basic_end got=busy exp=idle"); end
    total++;
    if (bus.seq_done !== 1'b1) begin bad++; $display("FAIL basic_seq_done got=%b exp=1", bus.seq_done); end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      got = (i < start_xs.size()) ? start_xs[i] : 16'hxxxx;
      total++;
      if (got !== ex[i]) begin bad++; $display("FAIL basic_sin_x[%0d] got=%h exp=%h", i, got, ex[i]); end
      got = (i < outs.size()) ? outs[i] : 16'hxxxx;
      total++;
      if (got !== eo[i]) begin bad++; $display("FAIL basic_out[%0d] got=%h exp=%h", i, got, eo[i]); end
    end
    total++;
    if (outs.size() != 3 || start_xs.size() != 3) begin
      bad++; $display("FAIL basic_counts got starts=%0d outs=%0d exp=3/3", start_xs.size(), outs.size());
    end
    total++;
    if (done_cnt != 1 || sd_cyc != hs_cyc + 1) begin
      bad++; $display("FAIL basic_done_timing got cnt=%0d sd=%0d hs=%0d exp cnt=1 sd=hs+1", done_cnt, sd_cyc, hs_cyc);
    end
    total++;
    if ({bus.busy, bus.seq_done} !== 2'b00) begin
      bad++; $display("FAIL basic_after got busy/seq_done=%b exp=00", {bus.busy, bus.seq_done});
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int n = 0;
    int s0;
    clear_logs();
    bus.out_ready = 1'b0;
    issue_go(16'h0000, 16'h2000, 8'd3);
    while (!bus.out_valid && n < 100) begin @(negedge clk); n++; end
    total++;
    if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid got=%b exp=1", bus.out_valid); end
    s0 = start_cnt;
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({bus.out_valid, bus.out_data, bus.sin_start} !== {1'b1, 16'h0001, 1'b0}) begin
        bad++; $display("FAIL bp_hold[%0d] got v=%b d=%h st=%b exp v=1 d=0001 st=0",
                        i, bus.out_valid, bus.out_data, bus.sin_start);
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.sin_x, bus.out_valid, bus.sin_start} !== {16'h2000, 1'b0, 1'b0} || start_cnt != s0) begin
      bad++; $display("FAIL bp_release got x=%h v=%b st=%b starts=%0d exp x=2000 v=0 st=0 starts=%0d",
                      bus.sin_x, bus.out_valid, bus.sin_start, start_cnt, s0);
    end
    @(negedge clk);
    total++;
    if (bus.sin_start !== 1'b1) begin bad++; $display("FAIL bp_next_start got=%b exp=1", bus.sin_start); end
    wait_idle(ok);
    @(negedge clk);
    total++;
    if (!ok || outs.size() != 3 || outs[1] !== 16'h2001 || outs[2] !== 16'h4001) begin
      bad++; $display("FAIL bp_outs got n=%0d exp n=3 with 0001,2001,4001", outs.size());
    end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [15:0] got;
    clear_logs();
    issue_go(16'h7000, 16'h2000, 8'd2);
    total++;
    if ({bus.sin_x, bus.busy, bus.sin_start} !== {16'h7000, 1'b1, 1'b0}) begin
      bad++; $display("FAIL wrap_setup got x=%h busy=%b st=%b exp x=7000 busy=1 st=0",
                      bus.sin_x, bus.busy, bus.sin_start);
    end
    @(negedge clk);
    total++;
    if ({bus.sin_x, bus.sin_start} !== {16'h7000, 1'b1}) begin
      bad++; $display("FAIL wrap_start got x=%h st=%b exp x=7000 st=1", bus.sin_x, bus.sin_start);
    end
    wait_idle(ok);
    @(negedge clk);
    got = (start_xs.size() > 1) ? start_xs[1] : 16'hxxxx;
    total++;
    if (got !== EXP_WRAP) begin bad++; $display("FAIL wrap_sin_x got=%h exp=%h", got, EXP_WRAP); end
    got = (outs.size() > 1) ? outs[1] : 16'hxxxx;
    total++;
    if (got !== EXP_WRAP + 16'd1) begin bad++; $display("FAIL wrap_out got=%h exp=%h", got, EXP_WRAP + 16'd1); end
  endtask

  task automatic test_timeout();
    bit ok;
    int idle_cyc;
    clear_logs();
    model_en = 1'b0;
    issue_go(16'h1234, 16'h0100, 8'd2);
    wait_idle(ok);
    idle_cyc = cyc;
    total++;
    if (!ok || idle_cyc - start_cyc != TIMEOUT_CYC + 1) begin
      bad++; $display("FAIL tmo_timing got idle-start=%0d exp=%0d", idle_cyc - start_cyc, TIMEOUT_CYC + 1);
    end
    total++;
    if (bus.err_timeout !== 1'b1) begin bad++; $display("FAIL tmo_err got=%b exp=1", bus.err_timeout); end
    repeat (3) @(negedge clk);
    total++;
    if ({bus.err_timeout, ov_seen} !== 2'b10 || done_cnt != 0) begin
      bad++; $display("FAIL tmo_quiet got err=%b ov_seen=%b dones=%0d exp err=1 ov=0 dones=0",
                      bus.err_timeout, ov_seen, done_cnt);
    end
    model_en = 1'b1;
    issue_go(16'h0000, 16'h0100, 8'd1);
    total++;
    if (bus.err_timeout !== 1'b0) begin bad++; $display("FAIL tmo_clear got=%b exp=0", bus.err_timeout); end
    wait_idle(ok);
    @(negedge clk);
    total++;
    if (outs.size() != 1 || outs[0] !== 16'h0001) begin
      bad++; $display("FAIL tmo_recover got n=%0d exp n=1 data=0001", outs.size());
    end
  endtask

  task automatic test_zero_and_busy_go();
    bit ok;
    int s0;
    logic [15:0] got;
    clear_logs();
    s0 = start_cnt;
    issue_go(16'h1111, 16'h0001, 8'd0);
    total++;
    if ({bus.seq_done, bus.busy} !== 2'b10) begin
      bad++; $display("FAIL zero_done got seq_done/busy=%b exp=10", {bus.seq_done, bus.busy});
    end
    @(negedge clk);
    total++;
    if (bus.seq_done !== 1'b0 || start_cnt != s0) begin
      bad++; $display("FAIL zero_pulse got seq_done=%b starts=%0d exp 0/%0d", bus.seq_done, start_cnt, s0);
    end
    clear_logs();
    issue_go(16'h0100, 16'h0100, 8'd2);
    repeat (4) @(negedge clk);
    total++;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL busy_go_pre got busy=%b exp=1", bus.busy); end
    issue_go(16'h5555, 16'h0001, 8'd5);
    wait_idle(ok);
    repeat (6) @(negedge clk);
    got = (start_xs.size() > 1) ? start_xs[1] : 16'hxxxx;
    total++;
    if (start_xs.size() != 2 || got !== 16'h0200) begin
      bad++; $display("FAIL busy_go_seq got n=%0d x1=%h exp n=2 x1=0200", start_xs.size(), got);
    end
    total++;
    if (done_cnt != 1 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL busy_go_end got dones=%0d busy=%b exp 1/0", done_cnt, bus.busy);
    end
  endtask

  task automatic test_reset_mid_wait();
    int n = 0;
    clear_logs();
    issue_go(16'h3000, 16'h0100, 8'd2);
    while (!bus.sin_start && n < 10) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    total++;
    if (bus.busy !== 1'b1 || bus.sin_x !== 16'h3000) begin
      bad++; $display("FAIL rstw_pre got busy=%b x=%h exp 1/3000", bus.busy, bus.sin_x);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.busy, bus.sin_start, bus.out_valid, bus.seq_done, bus.err_timeout, bus.sin_x, bus.out_data} !== 37'h0) begin
      bad++; $display("FAIL rstw_outputs got busy=%b st=%b v=%b sd=%b err=%b x=%h d=%h exp all 0",
                      bus.busy, bus.sin_start, bus.out_valid, bus.seq_done, bus.err_timeout,
                      bus.sin_x, bus.out_data);
    end
    rst = 1'b0;
    ov_seen = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if (ov_seen !== 1'b0 || bus.busy !== 1'b0 || outs.size() != 0) begin
      bad++; $display("FAIL rstw_late_done got ov_seen=%b busy=%b outs=%0d exp 0/0/0", ov_seen, bus.busy, outs.size());
    end
  endtask

  initial begin
    bus.go         = 1'b0;
    bus.cfg_phase0 = 16'h0;
    bus.cfg_step   = 16'h0;
    bus.cfg_count  = '0;
    bus.sin_result = 16'h0;
    bus.sin_done   = 1'b0;
    bus.out_ready  = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_timeout();
    test_zero_and_busy_go();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
